// File: rtl/if_fetch_unit_pkg.sv
// proc_pkg: shared constants and types for the instruction fetch stage.
package proc_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/acknowledge bus.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_unit_fifo.sv
// if_fifo: shift-register FIFO of {pc, instr}; entry 0 is the head, flush wins.
module if_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d, wr_idx;
    logic          do_pop;
    always_comb begin
        mem_d  = mem_q;
        do_pop = pop & (cnt_q != '0);
        wr_idx = cnt_q - CW'(do_pop);
        cnt_d  = flush ? '0 : wr_idx + CW'(push);
        if (do_pop)
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        if (push && wr_idx < CW'(DEPTH)) mem_d[wr_idx] = din;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
        mem_q <= mem_d;
    end
    assign count = cnt_q;
    assign head  = (cnt_q != '0) ? mem_q[0] : '{pc: 32'h0, instr: NOP_INSTR};
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, imem handshake, redirect/drain handling and output FIFO.
module if_fetch_unit
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    if_fetch_unit_if.master        imem,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    output logic [31:0]            out_PC,
    output logic [31:0]            out_INSTR,
    output logic [31:0]            out_PC_NEXT
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, target_q, target_d, rpc;
    logic          ack, push, pop;
    logic [CW-1:0] count, count_nx;
    fetch_entry_t  din, head;
    assign rpc      = {redirect_pc[31:2], 2'b00};
    assign ack      = imem.imem_ack & (state_q != IDLE);
    assign pop      = out_valid & ~stall & ~redirect;
    assign push     = ack & (state_q == REQ) & ~redirect;
    assign count_nx = count + CW'(push) - CW'(pop);
    assign din      = '{pc: fetch_pc_q, instr: imem.imem_rdata};
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    state_d    = REQ;
                    fetch_pc_d = rpc;
                end else if (count < FULL) state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    if (ack) fetch_pc_d = rpc;
                    else begin
                        state_d  = DRAIN;
                        target_d = rpc;
                    end
                end else begin
                    if (ack) fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d = (count_nx < FULL) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                // the outstanding beat is dropped; a same-cycle redirect supersedes the saved target
                if (ack) begin
                    state_d    = REQ;
                    fetch_pc_d = redirect ? rpc : target_q;
                end else if (redirect) target_d = rpc;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        imem.imem_req  = state_q != IDLE;
        imem.imem_addr = fetch_pc_q;
    end
    if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );
    assign out_valid   = count != '0;
    assign out_PC      = head.pc;
    assign out_INSTR   = head.instr;
    assign out_PC_NEXT = out_PC + 32'd4;
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage directly upstream of the IF/ID–EX/MEM pipeline register. Owns the fetch PC and the instruction-memory request/acknowledge handshake. Buffers fetched {PC, instruction} pairs in a small FIFO and presents them to the pipeline register with a valid flag. Handles redirects from branches and jumps, including discarding a fetch that is already in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, number of {PC, instruction} entries buffered; legal values 2..4

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
imem_req  out  1  instruction-memory request; held until imem_ack
imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and no ack
imem_ack  in  1  memory accepted the request; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
stall  in  1  downstream hazard or hold; head entry is not consumed
redirect  in  1  one-cycle pulse; fetch restarts at redirect_pc
redirect_pc  in  32  new fetch target; bits [1:0] ignored and forced to 0
out_valid  out  1  FIFO head holds a valid instruction; pipeline register ENABLE = out_valid & ~stall
out_PC  out  32  PC of the head instruction; 0 when empty
out_INSTR  out  32  head instruction; NOP (32'h0) when empty
out_PC_NEXT  out  32  out_PC + 4, used for link/branch computation

Behaviour:
- Reset (RESET=1 at a clock edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_PC=0, out_INSTR=0, out_PC_NEXT=4.
  - Reset overrides redirect, ack and stall in the same cycle.
  - Reset mid-request abandons the request. The memory must tolerate the dropped request; no drain is performed.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: imem_req=0. Go to REQ when count < FIFO_DEPTH. The first request is issued in the cycle after reset deasserts.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack: push {fetch_pc, imem_rdata} and set fetch_pc += 4 (wraps modulo 2^32).
    - Stay in REQ if the next count (count + push − pop) < FIFO_DEPTH; otherwise go to IDLE.
  - DRAIN: a redirect arrived while a request was outstanding. Keep imem_req=1 with the old address until imem_ack, then discard the data (no push), load the saved target and go to REQ.
- Handshake:
  - imem_addr changes only in the cycle after an ack or a redirect in a no-ack cycle from IDLE.
  - A zero-wait memory (ack in the same cycle as req) gives one instruction per cycle.
  - An ack while imem_req=0 is ignored.
- Pop: when out_valid & ~stall. Head outputs are registers and update on the next edge.
- Latency: ack at edge N with FIFO empty gives out_valid=1 after edge N.
- Simultaneous push and pop: count is unchanged and order is preserved.
- Redirect (highest priority after reset):
  - FIFO is flushed; out_valid=0 after the edge, and no pop occurs that cycle.
  - From IDLE: fetch_pc=redirect_pc, go to REQ.
  - From REQ with no ack this cycle: go to DRAIN and save the target.
  - From REQ with imem_ack in the same cycle: the acked data is discarded, fetch_pc=redirect_pc, stay in REQ.
  - A redirect during DRAIN overwrites the saved target and stays in DRAIN.
- Full FIFO: no request is issued, so an overflow cannot occur. Stall with a full FIFO holds all outputs indefinitely.
- Empty FIFO: out_valid=0 and out_INSTR=NOP. A stall while empty has no effect.

Decomposition:
- Package proc_pkg:
  - NOP_INSTR=32'h0.
  - FETCH_STATE encoding: IDLE=2'd0, REQ=2'd1, DRAIN=2'd2.
  - Default RESET_PC.
- Sub-module if_fifo: synchronous FIFO of {PC[31:0], INSTR[31:0]}, depth FIFO_DEPTH.
  - Ports: push, pop, flush, count, head outputs.
  - flush has priority over push and pop.

Test Plan:
1. Reset with RESET_PC=0x100 and zero-wait memory returning instr=addr^0xA5A5_0000 → imem_addr sequence 0x100, 0x104, 0x108; out_PC follows one cycle behind the acks; out_PC_NEXT=out_PC+4.
2. stall held 5 cycles with DEPTH=2 → imem_req drops after 2 acks, count=2, out_PC=0x100 stable; release stall → 0x100 then 0x104 consumed on consecutive cycles and fetch resumes at 0x108.
3. Memory with 3-cycle ack latency and redirect to 0x200 in the 2nd wait cycle → imem_addr stays at the old value until ack; data is discarded; next request is at 0x200; out_valid=0 until 0x200 returns.
4. redirect to 0x40 in the same cycle as imem_ack for 0x10C → 0x10C is never presented; the next out_PC is 0x40.
5. RESET pulsed while in DRAIN → imem_req=0 after the edge, FIFO empty, first new request at RESET_PC.
6. redirect_pc=0xFFFF_FFFE → fetch at 0xFFFF_FFFC, then wrap to 0x0000_0000.
